// File: rtl/ofm_tile_writer.sv
`default_nettype none
// ============================================================================
// Module   : ofm_tile_writer
// Purpose  : Captures a full NUM_OF_PE-lane OFM vector when all PE lanes are
//            valid. It then serialises the vector into BEAT_LANES-wide write
//            beats, addressed channel-major/raster into the OFM buffer. A
//            tile_done pulse is returned to the sequencer once a tile is fully
//            written.
// Ports    : clk, reset_n        - clock, async active-low reset
//            ofm_in, ofm_valid   - PE output vector and per-lane valids
//            cap_ready           - block is idle and can capture a tile
//            soft_clear          - synchronous abort, returns to idle
//            wr_en/wr_ready      - write beat handshake
//            wr_addr, wr_data    - element address of lane 0, beat data
//            tile_done           - pulse when the last beat of a tile lands
//            layer_done          - pulse with the last tile_done of a layer
//            overrun             - sticky, full vector seen while busy
// Revision : 1.0 - initial release
// ============================================================================
module ofm_tile_writer #(
   parameter int NUM_OF_PE  = 256,
   parameter int DATA_W     = 8,
   parameter int OFM_W      = 32,
   parameter int OFM_H      = 32,
   parameter int OFM_C      = 2,
   parameter int BEAT_LANES = 16,
   parameter int ADDR_W     = 16
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_OF_PE*DATA_W-1:0]    ofm_in,
   input  logic [NUM_OF_PE-1:0]           ofm_valid,
   output logic                           cap_ready,
   input  logic                           soft_clear,
   output logic                           wr_en,
   input  logic                           wr_ready,
   output logic [ADDR_W-1:0]              wr_addr,
   output logic [BEAT_LANES*DATA_W-1:0]   wr_data,
   output logic                           tile_done,
   output logic                           layer_done,
   output logic                           overrun
);

   localparam int TPC     = OFM_W * OFM_H / NUM_OF_PE;
   localparam int NT      = TPC * OFM_C;
   localparam int NB      = NUM_OF_PE / BEAT_LANES;
   localparam int BEAT_W  = BEAT_LANES * DATA_W;
   localparam int TILE_W  = (NT > 1) ? $clog2(NT) : 1;
   localparam int BEAT_IW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state;
   logic [TILE_W-1:0]    tile_idx;
   logic [BEAT_IW-1:0]   beat_idx;
   logic [BEAT_W-1:0]    shadow [NB];

   logic                 full;
   logic                 capture;
   logic                 last_beat;
   logic                 last_tile;
   logic [BEAT_IW-1:0]   next_beat;

   // Channel-major, raster-within-channel element address of a beat.
   function automatic logic [ADDR_W-1:0] beat_addr(input int tile, input int beat);
      int a;
      a = (tile / TPC) * (OFM_W * OFM_H) + (tile % TPC) * NUM_OF_PE + beat * BEAT_LANES;
      return a[ADDR_W-1:0];
   endfunction

   assign full      = &ofm_valid;
   assign capture   = (state == IDLE) && full && !soft_clear;
   assign last_beat = (beat_idx == BEAT_IW'(NB - 1));
   assign last_tile = (tile_idx == TILE_W'(NT - 1));
   assign next_beat = beat_idx + BEAT_IW'(1);

   // Shadow buffer holds the tile so ofm_in may change right after capture.
   // Beat 0 is forwarded straight from ofm_in at the capture edge, so only
   // beats 1..NB-1 are ever read back from here.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int b = 0; b < NB; b++) begin
            shadow[b] <= ofm_in[b*BEAT_W +: BEAT_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         tile_idx   <= '0;
         beat_idx   <= '0;
         cap_ready  <= 1'b1;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         tile_done  <= 1'b0;
         layer_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         tile_done  <= 1'b0;
         layer_done <= 1'b0;

         // A vector offered while busy is dropped; flag it until reset.
         if (full && (state != IDLE)) begin
            overrun <= 1'b1;
         end

         if (soft_clear) begin
            state     <= IDLE;
            tile_idx  <= '0;
            beat_idx  <= '0;
            cap_ready <= 1'b1;
            wr_en     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (full) begin
                     state     <= DRAIN;
                     beat_idx  <= '0;
                     cap_ready <= 1'b0;
                     wr_en     <= 1'b1;
                     wr_addr   <= beat_addr(int'(tile_idx), 0);
                     wr_data   <= ofm_in[0 +: BEAT_W];
                  end
               end
               DRAIN: begin
                  // Address/data only move on acceptance, so they hold in stalls.
                  if (wr_ready) begin
                     if (last_beat) begin
                        state      <= DONE;
                        wr_en      <= 1'b0;
                        tile_done  <= 1'b1;
                        layer_done <= last_tile;
                     end else begin
                        beat_idx <= next_beat;
                        wr_addr  <= beat_addr(int'(tile_idx), int'(next_beat));
                        wr_data  <= shadow[next_beat];
                     end
                  end
               end
               DONE: begin
                  state     <= IDLE;
                  cap_ready <= 1'b1;
                  tile_idx  <= last_tile ? '0 : tile_idx + TILE_W'(1);
               end
               default: begin
                  state     <= IDLE;
                  cap_ready <= 1'b1;
                  wr_en     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ofm_tile_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofm_tile_writer
// Purpose  : Directed self-checking bench for ofm_tile_writer. It covers reset
//            values, async reset mid-drain, eight consecutive tiles with layer
//            wrap, random write stalls, partial-valid rejection, overrun, and
//            soft_clear abort.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofm_tile_writer;

   localparam int NUM_OF_PE  = 256;
   localparam int DATA_W     = 8;
   localparam int BEAT_LANES = 16;
   localparam int ADDR_W     = 16;
   localparam int NB         = 16;
   localparam int NT         = 8;
   localparam int BEAT_W     = BEAT_LANES * DATA_W;

   logic                          clk;
   logic                          reset_n;
   logic [NUM_OF_PE*DATA_W-1:0]   ofm_in;
   logic [NUM_OF_PE-1:0]          ofm_valid;
   logic                          cap_ready;
   logic                          soft_clear;
   logic                          wr_en;
   logic                          wr_ready;
   logic [ADDR_W-1:0]             wr_addr;
   logic [BEAT_W-1:0]             wr_data;
   logic                          tile_done;
   logic                          layer_done;
   logic                          overrun;

   int checks   = 0;
   int failures = 0;

   ofm_tile_writer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ofm_in     (ofm_in),
      .ofm_valid  (ofm_valid),
      .cap_ready  (cap_ready),
      .soft_clear (soft_clear),
      .wr_en      (wr_en),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .tile_done  (tile_done),
      .layer_done (layer_done),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Lane k of a tile carries (k + seed) mod 256.
   function automatic logic [NUM_OF_PE*DATA_W-1:0] pattern(input int seed);
      logic [NUM_OF_PE*DATA_W-1:0] v;
      for (int k = 0; k < NUM_OF_PE; k++) v[k*DATA_W +: DATA_W] = 8'(k + seed);
      return v;
   endfunction

   function automatic logic [BEAT_W-1:0] exp_beat(input int seed, input int b);
      logic [BEAT_W-1:0] v;
      for (int j = 0; j < BEAT_LANES; j++) v[j*DATA_W +: DATA_W] = 8'(b*BEAT_LANES + j + seed);
      return v;
   endfunction

   // 4 tiles per channel, 1024 elements per channel.
   function automatic logic [ADDR_W-1:0] exp_addr(input int tile, input int b);
      return 16'((tile / 4) * 1024 + (tile % 4) * 256 + b * 16);
   endfunction

   task automatic run_tile(input int seed, input int tile, input bit stall,
                           input int ovr_iter, input int stop_beat);
      int beats, cyc, iter;
      bit acc;
      ofm_in    = pattern(seed);
      ofm_valid = '1;
      wr_ready  = 1'b1;
      tick;
      ofm_valid = '0;
      ofm_in    = ~ofm_in;
      chk("cap_ready_busy", cap_ready, 0);
      beats = 0; cyc = 0; iter = 0;
      while (beats < stop_beat && iter < 400) begin
         wr_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         ofm_valid = (iter == ovr_iter) ? '1 : '0;
         chk("wr_en", wr_en, 1);
         chk("wr_addr", wr_addr, exp_addr(tile, beats));
         chk("wr_data", wr_data, exp_beat(seed, beats));
         if (seed == 0 && beats == 0)
            chk("beat0_literal", wr_data, 128'h0F0E0D0C0B0A09080706050403020100);
         if (seed == 0 && beats == 15)
            chk("beat15_addr", wr_addr, 240);
         acc = wr_en && wr_ready;
         tick;
         cyc++; iter++;
         if (acc) beats++;
      end
      ofm_valid = '0;
      if (iter >= 400) chk("beat_timeout", 128'(beats), 128'(stop_beat));
      if (stop_beat < NB) return;
      chk("wr_en_done", wr_en, 0);
      chk("tile_done", tile_done, 1);
      chk("layer_done", layer_done, (tile == NT - 1));
      if (!stall) chk("tile_done_latency", 128'(cyc), 128'(NB));
      if (ovr_iter >= 0) chk("overrun_set", overrun, 1);
      tick;
      chk("tile_done_clear", tile_done, 0);
      chk("layer_done_clear", layer_done, 0);
      chk("cap_ready_back", cap_ready, 1);
   endtask

   initial begin
      reset_n    = 1'b0;
      ofm_in     = '0;
      ofm_valid  = '0;
      soft_clear = 1'b0;
      wr_ready   = 1'b0;
      tick; tick;

      chk("rst_cap_ready", cap_ready, 1);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_tile_done", tile_done, 0);
      chk("rst_layer_done", layer_done, 0);
      chk("rst_overrun", overrun, 0);
      reset_n = 1'b1;
      tick;

      // Async reset while beat 5 is presented.
      run_tile(8'h33, 0, 1'b0, -1, 5);
      reset_n = 1'b0;
      #1;
      chk("async_rst_wr_en", wr_en, 0);
      chk("async_rst_cap_ready", cap_ready, 1);
      chk("async_rst_wr_addr", wr_addr, 0);
      chk("async_rst_wr_data", wr_data, 0);
      tick; tick;
      reset_n = 1'b1;
      tick;

      // Full layer of 8 tiles, no stalls; tile 7 raises layer_done.
      for (int t = 0; t < NT; t++) run_tile(t * 9, t, 1'b0, -1, NB);

      // Wrapped back to tile 0; random stalls must not disturb data.
      run_tile(8'h5A, 0, 1'b1, -1, NB);
      run_tile(8'hA5, 1, 1'b1, -1, NB);

      // Partial valid vector must not capture.
      ofm_in    = pattern(8'h77);
      ofm_valid = ~256'd1;
      tick; tick;
      chk("partial_wr_en", wr_en, 0);
      chk("partial_cap_ready", cap_ready, 1);
      chk("overrun_clear", overrun, 0);
      ofm_valid = '0;
      tick;

      // Full vector during DRAIN sets overrun; beats stay those of tile 2.
      run_tile(8'h11, 2, 1'b0, 3, NB);

      // soft_clear at beat 7 of tile 3.
      run_tile(8'h22, 3, 1'b0, -1, 7);
      soft_clear = 1'b1;
      tick;
      soft_clear = 1'b0;
      chk("sc_wr_en", wr_en, 0);
      chk("sc_tile_done", tile_done, 0);
      chk("sc_cap_ready", cap_ready, 1);
      tick;
      chk("sc_no_tile_done", tile_done, 0);
      chk("overrun_sticky", overrun, 1);

      // Counters cleared: next tile is tile 0 at address 0.
      run_tile(8'h44, 0, 1'b0, -1, NB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
